// File: rtl/pe_fetch_stage.sv
// PE fetch stage: walks the ipad/wpad read addresses of one 1-D convolution pass
// and lines up each returned ipix/wpix pair with the control flags the sum stage uses.
module pe_fetch_stage #(
    parameter int unsigned DWd     = 8,
    parameter int unsigned IPadAWd = 4,
    parameter int unsigned WPadAWd = 8,
    parameter int unsigned CntWd   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ctl_reset,
    input  logic               i_ctl_stall,
    input  logic               i_start,
    input  logic [CntWd-1:0]   i_cfg_ntap,
    input  logic [CntWd-1:0]   i_cfg_nopix,
    input  logic [1:0]         i_cfg_stride,
    input  logic [WPadAWd-1:0] i_cfg_wbase,
    input  logic               i_cfg_init,
    output logic               o_ipad_re,
    output logic [IPadAWd-1:0] o_ipad_raddr,
    input  logic [DWd-1:0]     i_ipad_rdata,
    output logic               o_wpad_re,
    output logic [WPadAWd-1:0] o_wpad_raddr,
    input  logic [DWd-1:0]     i_wpad_rdata,
    output logic [DWd-1:0]     o_ipix,
    output logic [DWd-1:0]     o_wpix,
    output logic               o_ctl_valid,
    output logic               o_ctl_init,
    output logic               o_ctl_fstpix,
    output logic               o_ctl_lstpix,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CntWd-1:0]     ntap_q, ntap_d;
    logic [CntWd-1:0]     nopix_q, nopix_d;
    logic [1:0]           stride_q, stride_d;
    logic [WPadAWd-1:0]   wbase_q, wbase_d;
    logic                 init_q, init_d;
    logic [CntWd-1:0]     tap_q, tap_d;
    logic [CntWd-1:0]     opix_q, opix_d;
    logic [IPadAWd-1:0]   ibase_q, ibase_d;
    logic                 s1_vld_q, s1_vld_d;
    logic                 s1_init_q, s1_init_d;
    logic                 s1_fst_q, s1_fst_d;
    logic                 s1_lst_q, s1_lst_d;
    logic                 done_q, done_d;

    logic                 issue_c;
    logic                 consume_c;
    logic                 last_tap_c;

    always_comb begin
        state_d      = state_q;
        ntap_d       = ntap_q;
        nopix_d      = nopix_q;
        stride_d     = stride_q;
        wbase_d      = wbase_q;
        init_d       = init_q;
        tap_d        = tap_q;
        opix_d       = opix_q;
        ibase_d      = ibase_q;
        s1_vld_d     = s1_vld_q;
        s1_init_d    = s1_init_q;
        s1_fst_d     = s1_fst_q;
        s1_lst_d     = s1_lst_q;
        done_d       = 1'b0;
        issue_c      = 1'b0;
        o_ipad_raddr = '0;
        o_wpad_raddr = '0;
        consume_c    = s1_vld_q & ~i_ctl_stall;
        last_tap_c   = (tap_q == (ntap_q - CntWd'(1)));

        // A consumed beat empties s1 unless a new issue refills it below
        if (consume_c) begin
            s1_vld_d  = 1'b0;
            s1_init_d = 1'b0;
            s1_fst_d  = 1'b0;
            s1_lst_d  = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (i_start && (i_cfg_ntap != '0) && (i_cfg_nopix != '0)) begin
                    ntap_d   = i_cfg_ntap;
                    nopix_d  = i_cfg_nopix;
                    stride_d = i_cfg_stride;
                    wbase_d  = i_cfg_wbase;
                    init_d   = i_cfg_init;
                    tap_d    = '0;
                    opix_d   = '0;
                    ibase_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (!i_ctl_stall) begin
                    issue_c      = 1'b1;
                    o_ipad_raddr = ibase_q + IPadAWd'(tap_q);
                    o_wpad_raddr = wbase_q + WPadAWd'(tap_q);
                    s1_vld_d     = 1'b1;
                    s1_init_d    = init_q;
                    s1_fst_d     = (tap_q == '0);
                    s1_lst_d     = last_tap_c;
                    if (last_tap_c) begin
                        tap_d   = '0;
                        opix_d  = opix_q + CntWd'(1);
                        ibase_d = ibase_q + IPadAWd'(stride_q);
                        if (opix_q == (nopix_q - CntWd'(1))) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        tap_d = tap_q + CntWd'(1);
                    end
                end
            end
            DRAIN: begin
                if (consume_c) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Soft clear wins over everything, including a same-cycle start
        if (i_ctl_reset) begin
            state_d   = IDLE;
            ntap_d    = '0;
            nopix_d   = '0;
            stride_d  = '0;
            wbase_d   = '0;
            init_d    = 1'b0;
            tap_d     = '0;
            opix_d    = '0;
            ibase_d   = '0;
            s1_vld_d  = 1'b0;
            s1_init_d = 1'b0;
            s1_fst_d  = 1'b0;
            s1_lst_d  = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ntap_q    <= '0;
            nopix_q   <= '0;
            stride_q  <= '0;
            wbase_q   <= '0;
            init_q    <= 1'b0;
            tap_q     <= '0;
            opix_q    <= '0;
            ibase_q   <= '0;
            s1_vld_q  <= 1'b0;
            s1_init_q <= 1'b0;
            s1_fst_q  <= 1'b0;
            s1_lst_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ntap_q    <= ntap_d;
            nopix_q   <= nopix_d;
            stride_q  <= stride_d;
            wbase_q   <= wbase_d;
            init_q    <= init_d;
            tap_q     <= tap_d;
            opix_q    <= opix_d;
            ibase_q   <= ibase_d;
            s1_vld_q  <= s1_vld_d;
            s1_init_q <= s1_init_d;
            s1_fst_q  <= s1_fst_d;
            s1_lst_q  <= s1_lst_d;
            done_q    <= done_d;
        end
    end

    assign o_ipad_re    = issue_c;
    assign o_wpad_re    = issue_c;
    assign o_ipix       = i_ipad_rdata;
    assign o_wpix       = i_wpad_rdata;
    assign o_ctl_valid  = s1_vld_q;
    assign o_ctl_init   = s1_init_q;
    assign o_ctl_fstpix = s1_fst_q;
    assign o_ctl_lstpix = s1_lst_q;
    assign o_busy       = (state_q != IDLE);
    assign o_done       = done_q;

endmodule

// File: tb/tb_pe_fetch_stage.sv
// Bench for pe_fetch_stage: pad memories model, expected beats queued per pass,
// a monitor pops and checks each consumed beat; per-cycle logs cover timing checks.
module tb_pe_fetch_stage;

    typedef struct packed {
        logic [7:0] ipix;
        logic [7:0] wpix;
        logic       init;
        logic       fst;
        logic       lst;
    } beat_t;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_ctl_reset = 1'b0;
    logic       i_ctl_stall = 1'b0;
    logic       i_start = 1'b0;
    logic [3:0] i_cfg_ntap = '0;
    logic [3:0] i_cfg_nopix = '0;
    logic [1:0] i_cfg_stride = '0;
    logic [7:0] i_cfg_wbase = '0;
    logic       i_cfg_init = 1'b0;
    logic       o_ipad_re, o_wpad_re;
    logic [3:0] o_ipad_raddr;
    logic [7:0] o_wpad_raddr;
    logic [7:0] ipad_rdata = '0;
    logic [7:0] wpad_rdata = '0;
    logic [7:0] o_ipix, o_wpix;
    logic       o_ctl_valid, o_ctl_init, o_ctl_fstpix, o_ctl_lstpix, o_busy, o_done;

    logic [7:0] ipad_mem [16];
    logic [7:0] wpad_mem [256];

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fail = 0;

    logic [3:0] ia_log   [128];
    logic [7:0] wa_log   [128];
    logic [1:0] re_log   [128];
    logic       busy_log [128];
    logic       vld_log  [128];
    logic [1:0] fl_log   [128];
    logic [7:0] ipix_log [128];
    logic [7:0] wpix_log [128];

    int t1_ia [6] = '{0, 1, 2, 1, 2, 3};
    int t1_wa [6] = '{8, 9, 10, 8, 9, 10};
    int t4_ia [4] = '{14, 15, 0, 1};
    int t4_wa [4] = '{254, 255, 0, 1};

    pe_fetch_stage dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_ctl_reset  (i_ctl_reset),
        .i_ctl_stall  (i_ctl_stall),
        .i_start      (i_start),
        .i_cfg_ntap   (i_cfg_ntap),
        .i_cfg_nopix  (i_cfg_nopix),
        .i_cfg_stride (i_cfg_stride),
        .i_cfg_wbase  (i_cfg_wbase),
        .i_cfg_init   (i_cfg_init),
        .o_ipad_re    (o_ipad_re),
        .o_ipad_raddr (o_ipad_raddr),
        .i_ipad_rdata (ipad_rdata),
        .o_wpad_re    (o_wpad_re),
        .o_wpad_raddr (o_wpad_raddr),
        .i_wpad_rdata (wpad_rdata),
        .o_ipix       (o_ipix),
        .o_wpix       (o_wpix),
        .o_ctl_valid  (o_ctl_valid),
        .o_ctl_init   (o_ctl_init),
        .o_ctl_fstpix (o_ctl_fstpix),
        .o_ctl_lstpix (o_ctl_lstpix),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    // Pads: one-cycle read latency, output held while re is low
    always @(posedge clk) begin
        if (o_ipad_re) ipad_rdata <= ipad_mem[o_ipad_raddr];
        if (o_wpad_re) wpad_rdata <= wpad_mem[o_wpad_raddr];
    end

    function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    function automatic void check_cleared(input string nm);
        check({nm, "_ctl"}, 64'({o_ctl_valid, o_ctl_init, o_ctl_fstpix, o_ctl_lstpix,
                                  o_ipad_re, o_wpad_re, o_busy, o_done}), 64'(0));
        check({nm, "_addr"}, 64'({o_ipad_raddr, o_wpad_raddr}), 64'(0));
    endfunction

    // Monitor: every consumed beat must match the head of the scoreboard
    always @(negedge clk) begin
        beat_t got, exp;
        if (!i_rst && o_ctl_valid && !i_ctl_stall) begin
            got = '{ipix: o_ipix, wpix: o_wpix, init: o_ctl_init, fst: o_ctl_fstpix, lst: o_ctl_lstpix};
            if (sb.size() == 0) begin
                check("beat_unexpected", 64'(got), 64'(0));
            end else begin
                exp = sb.pop_front();
                check("beat", 64'(got), 64'(exp));
            end
        end
    end

    // abort_kind: 0 none, 1 async i_rst after sampling cycle abort_cyc, 2 i_ctl_reset during abort_cyc
    task automatic run_pass(input string nm, input int r, input int np, input int st, input int wb,
                            input int ini, input int stall_lo, input int stall_hi,
                            input int abort_kind, input int abort_cyc, input int restart_cyc,
                            input int max_cyc, input int exp_done);
        int done_cyc = -1;
        int done_cnt = 0;
        for (int o = 0; o < np; o++) begin
            for (int t = 0; t < r; t++) begin
                sb.push_back('{ipix: ipad_mem[(o * st + t) % 16], wpix: wpad_mem[(wb + t) % 256],
                               init: 1'(ini), fst: (t == 0), lst: (t == r - 1)});
            end
        end
        @(posedge clk); #1;
        i_cfg_ntap   = 4'(r);
        i_cfg_nopix  = 4'(np);
        i_cfg_stride = 2'(st);
        i_cfg_wbase  = 8'(wb);
        i_cfg_init   = 1'(ini);
        i_start      = 1'b1;
        for (int k = 0; k <= max_cyc; k++) begin
            i_ctl_stall = (k >= stall_lo) && (k <= stall_hi);
            i_ctl_reset = (abort_kind == 2) && (k == abort_cyc);
            if (k == restart_cyc) begin
                i_start     = 1'b1;
                i_cfg_ntap  = 4'd1;
                i_cfg_nopix = 4'd1;
                i_cfg_wbase = 8'h40;
            end
            @(negedge clk);
            ia_log[k]   = o_ipad_raddr;
            wa_log[k]   = o_wpad_raddr;
            re_log[k]   = {o_ipad_re, o_wpad_re};
            busy_log[k] = o_busy;
            vld_log[k]  = o_ctl_valid;
            fl_log[k]   = {o_ctl_fstpix, o_ctl_lstpix};
            ipix_log[k] = o_ipix;
            wpix_log[k] = o_wpix;
            if (o_done) begin
                done_cnt++;
                done_cyc = k;
            end
            if (abort_kind == 1 && k == abort_cyc) begin
                #2 i_rst = 1'b1;
                #1 check_cleared({nm, "_async"});
                sb.delete();
            end
            @(posedge clk); #1;
            i_start = 1'b0;
            if (abort_kind == 1 && k == abort_cyc) i_rst = 1'b0;
            if (abort_kind == 2 && k == abort_cyc) begin
                check_cleared({nm, "_soft"});
                sb.delete();
            end
        end
        i_ctl_stall = 1'b0;
        i_ctl_reset = 1'b0;
        check({nm, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({nm, "_done_pulses"}, 64'(done_cnt), 64'((exp_done >= 0) ? 1 : 0));
        check({nm, "_sb_drained"}, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        for (int a = 0; a < 16; a++) ipad_mem[a] = 8'(a * 7 + 3);
        for (int a = 0; a < 256; a++) wpad_mem[a] = 8'(a) ^ 8'h5A;

        repeat (2) @(posedge clk);
        #1 check_cleared("reset");
        i_rst = 1'b0;

        // R=3, nopix=2, stride=1, wbase=8, init=1
        run_pass("t1", 3, 2, 1, 8, 1, 100, 0, 0, -1, -1, 8, 8);
        for (int c = 1; c <= 6; c++) begin
            check("t1_ipad_addr", 64'(ia_log[c]), 64'(t1_ia[c-1]));
            check("t1_wpad_addr", 64'(wa_log[c]), 64'(t1_wa[c-1]));
            check("t1_re", 64'(re_log[c]), 64'(3));
        end
        check("t1_re_after", 64'(re_log[7]), 64'(0));
        for (int c = 0; c <= 8; c++) begin
            check("t1_busy", 64'(busy_log[c]), 64'((c >= 1 && c <= 7) ? 1 : 0));
            check("t1_valid", 64'(vld_log[c]), 64'((c >= 2 && c <= 7) ? 1 : 0));
        end

        // Same pass, stall in cycles 3..5: beat with tap 1 is held
        run_pass("t2", 3, 2, 1, 8, 1, 3, 5, 0, -1, -1, 11, 11);
        for (int c = 3; c <= 5; c++) begin
            check("t2_re_stalled", 64'(re_log[c]), 64'(0));
            check("t2_hold", 64'({vld_log[c], fl_log[c], ipix_log[c], wpix_log[c]}),
                  64'({1'b1, 2'b00, ipad_mem[1], wpad_mem[9]}));
        end

        // R=1: every beat is both first and last tap
        run_pass("t3", 1, 4, 3, 8'h20, 0, 100, 0, 0, -1, -1, 6, 6);
        for (int c = 1; c <= 4; c++) check("t3_ipad_addr", 64'(ia_log[c]), 64'((c - 1) * 3));

        // Address wrap on both pads
        run_pass("t4", 4, 8, 2, 8'hFE, 1, 100, 0, 0, -1, -1, 35, 34);
        for (int c = 29; c <= 32; c++) begin
            check("t4_ipad_wrap", 64'(ia_log[c]), 64'(t4_ia[c-29]));
            check("t4_wpad_wrap", 64'(wa_log[c]), 64'(t4_wa[c-29]));
        end

        // Aborts at beat 3, then a normal pass
        run_pass("t5", 3, 2, 1, 8, 1, 100, 0, 1, 4, -1, 10, -1);
        run_pass("t6", 3, 2, 1, 8, 1, 100, 0, 2, 4, -1, 10, -1);
        run_pass("t7", 2, 3, 1, 8'h10, 0, 100, 0, 0, -1, -1, 9, 8);

        // Start with different cfg during RUN must not disturb the pass
        run_pass("t8", 3, 2, 1, 8, 1, 100, 0, 0, -1, 3, 9, 8);

        // Invalid cfg starts stay in IDLE
        @(posedge clk); #1;
        i_cfg_ntap  = 4'd0;
        i_cfg_nopix = 4'd2;
        i_start     = 1'b1;
        @(posedge clk); #1;
        i_cfg_ntap  = 4'd2;
        i_cfg_nopix = 4'd0;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bad_cfg_idle", 64'({o_busy, o_ipad_re, o_wpad_re, o_ctl_valid, o_done}), 64'(0));
        end
        check("bad_cfg_sb", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_fetch_stage.md
Name: pe_fetch_stage

Overview:
- Front stage of the PE datapath, directly upstream of the multiply stage (Aunit) and sum stage.
- Sequences reads of the input-pixel pad and weight pad for one 1-D convolution pass.
- Presents each ipix/wpix pair to the multiplier, aligned with the control flags the sum stage consumes: valid, init, fstpix, lstpix.

Parameters:
- DWd, 8, pixel / weight data width
- IPadAWd, 4, ipad address width (depth 2^IPadAWd)
- WPadAWd, 8, wpad address width
- CntWd, 4, width of the tap and output-pixel count fields

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_ctl_reset  in  1  synchronous soft clear
- i_ctl_stall  in  1  downstream stall; holds the output beat
- i_start  in  1  one-cycle pulse; latches the cfg fields
- i_cfg_ntap  in  CntWd  taps per output pixel R; 0 = invalid
- i_cfg_nopix  in  CntWd  output pixels per pass; 0 = invalid
- i_cfg_stride  in  2  ipad base increment per output pixel (0..3)
- i_cfg_wbase  in  WPadAWd  wpad base address
- i_cfg_init  in  1  pass starts psum from 0
- o_ipad_re  out  1  ipad read enable
- o_ipad_raddr  out  IPadAWd  ipad read address
- i_ipad_rdata  in  DWd  ipad data, 1-cycle latency, held while re=0
- o_wpad_re  out  1  wpad read enable
- o_wpad_raddr  out  WPadAWd  wpad read address
- i_wpad_rdata  in  DWd  wpad data, same timing as ipad
- o_ipix  out  DWd  = i_ipad_rdata (combinational pass-through)
- o_wpix  out  DWd  = i_wpad_rdata
- o_ctl_valid  out  1  beat valid
- o_ctl_init  out  1  cfg_init of the pass; meaningful with valid
- o_ctl_fstpix  out  1  beat is tap 0
- o_ctl_lstpix  out  1  beat is tap R-1
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse, pass complete

Behaviour:
- FSM states: IDLE, RUN, DRAIN.
- Two pipeline slots:
  - s0: address issue.
  - s1: registers valid/init/fstpix/lstpix; data comes from the pad outputs.
- IDLE:
  - i_start with ntap != 0 and nopix != 0: latch cfg; clear tap, opix and ibase counters; go to RUN next cycle.
  - Invalid cfg: start ignored, stay IDLE.
  - i_start in RUN or DRAIN: ignored, cfg unchanged.
- RUN, per cycle with i_ctl_stall=0:
  - Assert both re; ipad addr = ibase + tap (mod 2^IPadAWd); wpad addr = wbase + tap (mod 2^WPadAWd).
  - tap increments. At tap = R-1: tap <- 0, opix++, ibase += stride (wraps mod 2^IPadAWd, no multiplier).
  - Issue of opix = nopix-1, tap = R-1: go to DRAIN.
  - s1 <= {valid=1, fstpix=(tap==0), lstpix=(tap==R-1), init=cfg_init}.
- Stall (i_ctl_stall=1): re=0, counters hold, s1 holds. Pad data stays stable because re=0, so o_ipix/o_wpix stay aligned. Stall in IDLE has no effect.
- Beat consumed: o_ctl_valid & !i_ctl_stall. With no issue in that cycle, s1 valid clears.
- DRAIN: no issue. When the last beat is consumed, o_done=1 for one cycle, state -> IDLE, o_busy=0 in that same cycle.
- R=1: fstpix and lstpix both 1 on every beat.
- Latency and throughput:
  - Start at cycle 0: first re at cycle 1, first valid at cycle 2.
  - N = R*nopix beats; with no stalls, last valid at cycle 1+N and o_done at cycle 2+N.
  - One beat per unstalled cycle.
- Reset, async i_rst or sync i_ctl_reset (either, at any time, including mid-pass):
  - State IDLE; counters and cfg cleared; s1 valid/flags = 0.
  - o_ipad_re = o_wpad_re = 0; addresses = 0.
  - o_busy = 0, o_done = 0; no o_done pulse for the aborted pass.
  - o_ipix/o_wpix follow the pad data and are don't-care while valid=0.
- i_ctl_reset takes priority over i_start in the same cycle.

Test Plan:
- R=3, nopix=2, stride=1, wbase=8, init=1, no stall:
  - ipad addr 0,1,2,1,2,3; wpad 8,9,10,8,9,10 in cycles 1..6.
  - valid cycles 2..7; fstpix at cycles 2 and 5; lstpix at cycles 4 and 7; init=1 throughout.
  - o_done at cycle 8; o_busy high cycles 1..7.
- Same cfg with i_ctl_stall high in cycles 3..5:
  - s1 flags and o_ipix/o_wpix frozen (held beat 2); no re in cycles 3..5.
  - Beat sequence unchanged; o_done at cycle 11.
- R=1, nopix=4, stride=3, IPadAWd=4:
  - ipad addr 0,3,6,9; every beat has fstpix=lstpix=1.
- Wrap: stride=2, R=4, nopix=8:
  - last pixel ipad addrs 14,15,0,1 (mod 16).
- Aborts and ignored starts:
  - i_rst asserted asynchronously at beat 3: outputs cleared immediately; no o_done.
  - i_ctl_reset mid-pass: same effect, taking effect at the next clock edge.
  - A new start then runs normally.
  - i_start during RUN, and start with ntap=0, are both ignored.
